// File: rtl/key_cond_pkg.sv
// Shared types and counter-sizing helpers for the key conditioner.
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } key_state_t;

  // Bits needed to hold values 0..max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: 2-FF synchroniser, debounce, edge pulses and
// long-press / auto-repeat state machine.
module key_channel
  import key_cond_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic clk,
  input  logic rstn_signal,
  input  logic key_i,
  input  logic repeat_en,
  output logic key_level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(max_int(LONG_CYCLES, REPEAT_CYCLES));
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);
  localparam logic POL = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic r_sync1, r_sync2;
  logic r_level, r_press, r_release, r_long, r_repeat;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_next;
  key_state_t        r_state, w_state_next;
  logic w_synced, w_mismatch, w_accept, w_rise, w_fall;
  logic w_long_next, w_repeat_next;

  assign w_synced   = r_sync2 ^ POL;
  assign w_mismatch = (w_synced != r_level);
  assign w_accept   = w_mismatch && (r_db_cnt == DB_LAST);
  assign w_rise     = w_accept && w_synced;
  assign w_fall     = w_accept && !w_synced;

  // Sync flops come out of reset holding the "released" pin level.
  always_ff @(posedge clk or negedge rstn_signal) begin
    if (!rstn_signal) begin
      r_sync1 <= POL;
      r_sync2 <= POL;
    end else begin
      r_sync1 <= key_i;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rstn_signal) begin
    if (!rstn_signal) begin
      r_db_cnt  <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_rise;
      r_release <= w_fall;
      if (!w_mismatch || w_accept) r_db_cnt <= '0;
      else                         r_db_cnt <= r_db_cnt + 1'b1;
      if (w_accept) r_level <= w_synced;
    end
  end

  always_ff @(posedge clk or negedge rstn_signal) begin
    if (!rstn_signal) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_next;
      r_long     <= w_long_next;
      r_repeat   <= w_repeat_next;
    end
  end

  // The FSM follows the debounced edge in the same cycle key_level_o flips,
  // so long_o lands exactly LONG_CYCLES after press_o.
  always_comb begin
    w_state_next = r_state;
    if (w_fall) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_rise) w_state_next = PRESSED;
        PRESSED: if (r_hold_cnt == LONG_LAST) w_state_next = HELD;
        HELD:    w_state_next = HELD;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_hold_next   = r_hold_cnt;
    w_long_next   = 1'b0;
    w_repeat_next = 1'b0;
    if (w_fall) begin
      w_hold_next = '0;
    end else begin
      case (r_state)
        IDLE: w_hold_next = '0;
        PRESSED: begin
          if (r_hold_cnt == LONG_LAST) begin
            w_long_next = 1'b1;
            w_hold_next = '0;
          end else begin
            w_hold_next = r_hold_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!repeat_en) begin
            w_hold_next = '0;
          end else if (r_hold_cnt == REP_LAST) begin
            w_repeat_next = 1'b1;
            w_hold_next   = '0;
          end else begin
            w_hold_next = r_hold_cnt + 1'b1;
          end
        end
        default: w_hold_next = '0;
      endcase
    end
  end

  assign key_level_o = r_level;
  assign press_o     = r_press;
  assign release_o   = r_release;
  assign long_o      = r_long;
  assign repeat_o    = r_repeat;

endmodule

// File: rtl/key_conditioner.sv
// Multi-channel push-button front end: NKEYS independent key_channel
// instances plus a combined "any key down" flag.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int NKEYS           = 4,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic             clk,
  input  logic             rstn_signal,
  input  logic [NKEYS-1:0] key_i,
  input  logic [NKEYS-1:0] repeat_en,
  output logic [NKEYS-1:0] key_level_o,
  output logic [NKEYS-1:0] press_o,
  output logic [NKEYS-1:0] release_o,
  output logic [NKEYS-1:0] long_o,
  output logic [NKEYS-1:0] repeat_o,
  output logic             any_pressed_o
);

  for (genvar gi = 0; gi < NKEYS; gi++) begin : g_chan
    key_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk         (clk),
      .rstn_signal (rstn_signal),
      .key_i       (key_i[gi]),
      .repeat_en   (repeat_en[gi]),
      .key_level_o (key_level_o[gi]),
      .press_o     (press_o[gi]),
      .release_o   (release_o[gi]),
      .long_o      (long_o[gi]),
      .repeat_o    (repeat_o[gi])
    );
  end

  assign any_pressed_o = |key_level_o;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: an active-low and an active-high instance share
// one pressed/released stimulus and are both checked against one event model.
module tb_key_conditioner;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int LC = 20;
  localparam int RC = 5;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NK-1:0] press_a = '0;
  logic [NK-1:0] repeat_en = '0;
  logic [NK-1:0] key_a, key_b;

  logic [NK-1:0] a_level, a_press, a_release, a_long, a_repeat;
  logic [NK-1:0] b_level, b_press, b_release, b_long, b_repeat;
  logic          a_any, b_any;

  assign key_a = ~press_a;
  assign key_b = press_a;

  always #5 clk = ~clk;

  key_conditioner #(
    .NKEYS(NK), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LC), .REPEAT_CYCLES(RC)
  ) u_dut_a (
    .clk(clk), .rstn_signal(rstn), .key_i(key_a), .repeat_en(repeat_en),
    .key_level_o(a_level), .press_o(a_press), .release_o(a_release),
    .long_o(a_long), .repeat_o(a_repeat), .any_pressed_o(a_any)
  );

  key_conditioner #(
    .NKEYS(NK), .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LC), .REPEAT_CYCLES(RC)
  ) u_dut_b (
    .clk(clk), .rstn_signal(rstn), .key_i(key_b), .repeat_en(repeat_en),
    .key_level_o(b_level), .press_o(b_press), .release_o(b_release),
    .long_o(b_long), .repeat_o(b_repeat), .any_pressed_o(b_any)
  );

  // Event model: a level is accepted after DB consecutive synced samples
  // disagree with it; long/repeat timing is derived from cycle timestamps.
  int            m_cyc = 0;
  logic [NK-1:0] m_s1 = '0, m_s2 = '0;
  logic [DB-1:0] m_hist [NK];
  logic [NK-1:0] m_level = '0, m_press = '0, m_release = '0, m_long = '0, m_repeat = '0;
  bit            m_held [NK];
  int            m_press_at [NK];
  int            m_anchor [NK];

  always @(posedge clk) begin
    m_press = '0; m_release = '0; m_long = '0; m_repeat = '0;
    if (!rstn) begin
      m_s1 = '0; m_s2 = '0; m_level = '0;
      for (int c = 0; c < NK; c++) begin
        m_hist[c] = '0; m_held[c] = 1'b0; m_press_at[c] = 0; m_anchor[c] = 0;
      end
    end else begin
      m_cyc++;
      for (int c = 0; c < NK; c++) begin
        m_hist[c] = {m_hist[c][DB-2:0], m_s2[c]};
        if (m_level[c] ? (m_hist[c] == '0) : (m_hist[c] == '1)) begin
          m_level[c] = ~m_level[c];
          m_held[c]  = 1'b0;
          if (m_level[c]) begin
            m_press[c] = 1'b1;
            m_press_at[c] = m_cyc;
          end else begin
            m_release[c] = 1'b1;
          end
        end else if (m_level[c]) begin
          if (!m_held[c]) begin
            if (m_cyc - m_press_at[c] == LC) begin
              m_long[c] = 1'b1; m_held[c] = 1'b1; m_anchor[c] = m_cyc;
            end
          end else if (!repeat_en[c]) begin
            m_anchor[c] = m_cyc;
          end else if (m_cyc - m_anchor[c] == RC) begin
            m_repeat[c] = 1'b1; m_anchor[c] = m_cyc;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = press_a;
    end
  end

  int n_vec, n_err;
  int ev_press [NK], ev_rel [NK], ev_long [NK], ev_rep [NK], ev_lvl [NK];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < NK; c++) begin
      ev_press[c] = 0; ev_rel[c] = 0; ev_long[c] = 0; ev_rep[c] = 0; ev_lvl[c] = 0;
    end
  endtask

  // Advance one cycle per iteration, comparing both DUTs with the model.
  task automatic run(input int cyc);
    logic [20:0] exp_v, act_v;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      exp_v = {m_level, m_press, m_release, m_long, m_repeat, |m_level};
      act_v = {a_level, a_press, a_release, a_long, a_repeat, a_any};
      chk("model_dut_a", 32'(act_v), 32'(exp_v));
      act_v = {b_level, b_press, b_release, b_long, b_repeat, b_any};
      chk("model_dut_b", 32'(act_v), 32'(exp_v));
      for (int c = 0; c < NK; c++) begin
        ev_press[c] += int'(a_press[c]);
        ev_rel[c]   += int'(a_release[c]);
        ev_long[c]  += int'(a_long[c]);
        ev_rep[c]   += int'(a_repeat[c]);
        ev_lvl[c]   += int'(a_level[c]);
      end
      #1;
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    clr();
    run(3);
    rstn = 1'b1;
    run(2);
    chk("reset_outputs_a", 32'({a_level, a_press, a_release, a_long, a_repeat, a_any}), 32'd0);
    chk("reset_outputs_b", 32'({b_level, b_press, b_release, b_long, b_repeat, b_any}), 32'd0);

    // Basic press / release on key 0
    clr();
    press_a[0] = 1'b1;
    run(5);
    chk("t1_level_before", 32'(a_level[0]), 32'd0);
    run(1);
    chk("t1_level_rise", 32'(a_level[0]), 32'd1);
    chk("t1_press_pulse", 32'(a_press), 32'h1);
    run(1);
    chk("t1_press_single", 32'(a_press[0]), 32'd0);
    run(3);
    press_a[0] = 1'b0;
    run(5);
    chk("t1_level_hold", 32'(a_level[0]), 32'd1);
    run(1);
    chk("t1_release_pulse", 32'({a_level[0], a_release[0]}), 32'b01);
    run(30);
    chk("t1_counts", 32'({ev_press[0][7:0], ev_rel[0][7:0], ev_long[0][7:0]}), 32'h010100);

    // Glitch rejection on key 1
    clr();
    for (int g = 0; g < 5; g++) begin
      press_a[1] = 1'b1; run(3);
      press_a[1] = 1'b0; run(3);
    end
    run(10);
    chk("t2_glitch", 32'({ev_lvl[1][7:0], ev_press[1][7:0], ev_rel[1][7:0]}), 32'd0);

    // Long press with repeat on key 2
    clr();
    repeat_en[2] = 1'b1;
    press_a[2] = 1'b1;
    run(6);
    chk("t3_press", 32'(a_press[2]), 32'd1);
    run(20);
    chk("t3_long", 32'(a_long), 32'h4);
    run(5);
    chk("t3_repeat1", 32'(a_repeat), 32'h4);
    run(19);
    press_a[2] = 1'b0;
    run(30);
    chk("t3_counts", 32'({ev_press[2][7:0], ev_long[2][7:0], ev_rep[2][7:0], ev_rel[2][7:0]}), 32'h01010501);

    // Repeat disabled, then release colliding with the long timeout
    clr();
    repeat_en[3] = 1'b0;
    press_a[3] = 1'b1;
    run(40);
    press_a[3] = 1'b0;
    run(30);
    chk("t4_norepeat", 32'({ev_long[3][7:0], ev_rep[3][7:0], ev_rel[3][7:0]}), 32'h010001);
    clr();
    press_a[3] = 1'b1;
    run(6);
    chk("t4_press", 32'(a_press[3]), 32'd1);
    run(14);
    press_a[3] = 1'b0;
    run(6);
    chk("t4_collision", 32'({a_release[3], a_long[3]}), 32'b10);
    run(30);
    chk("t4_nolong", 32'(ev_long[3]), 32'd0);

    // Repeat gated off mid-hold restarts a full period on key 1
    clr();
    repeat_en[1] = 1'b1;
    press_a[1] = 1'b1;
    run(33);
    repeat_en[1] = 1'b0;
    run(3);
    repeat_en[1] = 1'b1;
    run(14);
    press_a[1] = 1'b0;
    run(30);
    chk("t7_regate", 32'({ev_long[1][7:0], ev_rep[1][7:0], ev_rel[1][7:0]}), 32'h010401);
    repeat_en[1] = 1'b0;

    // Reset in the middle of a long-press count
    clr();
    press_a[0] = 1'b1;
    run(6);
    chk("t5_press", 32'(a_press[0]), 32'd1);
    run(10);
    rstn = 1'b0;
    run(1);
    chk("t5_reset_a", 32'({a_level, a_press, a_release, a_long, a_repeat, a_any}), 32'd0);
    chk("t5_reset_b", 32'({b_level, b_press, b_release, b_long, b_repeat, b_any}), 32'd0);
    run(2);
    rstn = 1'b1;
    run(5);
    chk("t5_requalify_wait", 32'(a_press[0]), 32'd0);
    run(1);
    chk("t5_requalify_press", 32'(a_press[0]), 32'd1);
    run(19);
    chk("t5_long_early", 32'(a_long[0]), 32'd0);
    run(1);
    chk("t5_long", 32'(a_long[0]), 32'd1);
    press_a[0] = 1'b0;
    run(30);

    // All keys at once, both polarities
    press_a = 4'hF;
    run(6);
    chk("t6_press_a", 32'({a_press, a_any}), 32'h1F);
    chk("t6_press_b", 32'({b_press, b_any}), 32'h1F);
    run(3);
    press_a = 4'h0;
    run(6);
    chk("t6_release_b", 32'({b_release, b_any}), 32'h1E);
    run(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
